// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one IEEE-754 single-precision multiplier among
// NUM_REQ requesters through a two-stage (operand / result) pipeline.

module fpmul_core (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] p
);

   logic        sign_s;
   logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
   logic [47:0] prod_s;
   logic [9:0]  exp_s, exp_n_s, exp_f_s;
   logic [22:0] frac_s;
   logic        guard_s, sticky_s, round_s;
   logic [23:0] frac_r_s;

   // Round-to-nearest-even multiply; subnormal inputs and results flush to zero.
   always_comb begin
      sign_s   = a[31] ^ b[31];
      a_nan_s  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan_s  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf_s  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf_s  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_zero_s = (a[30:23] == 8'h00);
      b_zero_s = (b[30:23] == 8'h00);
      prod_s   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      exp_s    = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      if (prod_s[47]) begin
         frac_s   = prod_s[46:24];
         guard_s  = prod_s[23];
         sticky_s = |prod_s[22:0];
         exp_n_s  = exp_s + 10'd1;
      end else begin
         frac_s   = prod_s[45:23];
         guard_s  = prod_s[22];
         sticky_s = |prod_s[21:0];
         exp_n_s  = exp_s;
      end
      round_s  = guard_s & (sticky_s | frac_s[0]);
      frac_r_s = {1'b0, frac_s} + {23'd0, round_s};
      if (frac_r_s[23]) begin
         exp_f_s = exp_n_s + 10'd1;
      end else begin
         exp_f_s = exp_n_s;
      end
      // exp_f_s is two's complement: bit 9 set means underflow.
      if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
         p = 32'h7FC0_0000;
      end else if (a_inf_s || b_inf_s) begin
         p = {sign_s, 8'hFF, 23'd0};
      end else if (a_zero_s || b_zero_s) begin
         p = {sign_s, 31'd0};
      end else if (!exp_f_s[9] && (exp_f_s >= 10'd255)) begin
         p = {sign_s, 8'hFF, 23'd0};
      end else if (exp_f_s[9] || (exp_f_s == 10'd0)) begin
         p = {sign_s, 31'd0};
      end else begin
         p = {sign_s, exp_f_s[7:0], frac_r_s[22:0]};
      end
   end

endmodule

module fpmul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [32*NUM_REQ-1:0] req_x,
   input  logic [32*NUM_REQ-1:0] req_y,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [IDW-1:0]        rsp_id,
   output logic [15:0]           grant_count
);

   localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

   logic           s0_valid_q, s0_valid_d;
   logic [31:0]    s0_x_q, s0_x_d, s0_y_q, s0_y_d;
   logic [IDW-1:0] s0_id_q, s0_id_d;
   logic           s1_valid_q, s1_valid_d;
   logic [31:0]    s1_data_q, s1_data_d;
   logic [IDW-1:0] s1_id_q, s1_id_d;
   logic [IDW-1:0] last_q, last_d;
   logic [15:0]    grant_count_q, grant_count_d;

   logic           adv_s, found_s, accept_s;
   logic [IDW-1:0] grant_id_s;
   logic [31:0]    sel_x_s, sel_y_s, prod_s;
   int             idx_s;

   fpmul_core u_mul (
      .a (s0_x_q),
      .b (s0_y_q),
      .p (prod_s)
   );

   // Round-robin search starting just after the most recent grant.
   always_comb begin
      found_s    = 1'b0;
      grant_id_s = '0;
      idx_s      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_s = int'(last_q) + k;
         if (idx_s >= NUM_REQ) begin
            idx_s = idx_s - NUM_REQ;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req_valid[idx_s]) begin
            found_s    = 1'b1;
            grant_id_s = IDW'(idx_s);
         end else begin
            found_s    = found_s;
         end
      end
   end

   // Handshake: grants only issue while the pipeline can advance and reset is released.
   always_comb begin
      adv_s     = !s1_valid_q || rsp_ready;
      accept_s  = adv_s && found_s && rst_n;
      req_ready = '0;
      if (accept_s) begin
         req_ready[grant_id_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
      sel_x_s = req_x[32*int'(grant_id_s) +: 32];
      sel_y_s = req_y[32*int'(grant_id_s) +: 32];
   end

   // Pipeline advance and arbitration bookkeeping.
   always_comb begin
      s0_valid_d    = s0_valid_q;
      s0_x_d        = s0_x_q;
      s0_y_d        = s0_y_q;
      s0_id_d       = s0_id_q;
      s1_valid_d    = s1_valid_q;
      s1_data_d     = s1_data_q;
      s1_id_d       = s1_id_q;
      last_d        = last_q;
      grant_count_d = grant_count_q;
      if (adv_s) begin
         s1_valid_d = s0_valid_q;
         s1_data_d  = prod_s;
         s1_id_d    = s0_id_q;
         s0_valid_d = found_s;
         if (found_s) begin
            s0_x_d        = sel_x_s;
            s0_y_d        = sel_y_s;
            s0_id_d       = grant_id_s;
            last_d        = grant_id_s;
            grant_count_d = grant_count_q + 16'd1;
         end else begin
            s0_id_d = s0_id_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid_q    <= 1'b0;
         s0_x_q        <= 32'd0;
         s0_y_q        <= 32'd0;
         s0_id_q       <= '0;
         s1_valid_q    <= 1'b0;
         s1_data_q     <= 32'd0;
         s1_id_q       <= '0;
         last_q        <= LAST_RST;
         grant_count_q <= 16'd0;
      end else begin
         s0_valid_q    <= s0_valid_d;
         s0_x_q        <= s0_x_d;
         s0_y_q        <= s0_y_d;
         s0_id_q       <= s0_id_d;
         s1_valid_q    <= s1_valid_d;
         s1_data_q     <= s1_data_d;
         s1_id_q       <= s1_id_d;
         last_q        <= last_d;
         grant_count_q <= grant_count_d;
      end
   end

   assign rsp_valid   = s1_valid_q;
   assign rsp_data    = s1_data_q;
   assign rsp_id      = s1_id_q;
   assign grant_count = grant_count_q;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter: directed scenarios plus random traffic
// checked against a cycle-level reference built from the arbitration rules.

module tb_fpmul_arbiter;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_x;
   logic [127:0] req_y;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [31:0]  rsp_data;
   logic [2:0]   rsp_id;
   logic [15:0]  grant_count;

   int total;
   int bad;

   // reference state: operand stage, result stage, round-robin pointer, counter
   bit          m0_v, m1_v;
   logic [31:0] m0_d, m1_d;
   int          m0_id, m1_id, m_last;
   logic [15:0] m_cnt;
   int          last_grant;
   logic [3:0]  obs_rdy;

   fpmul_arbiter #(.NUM_REQ(4), .IDW(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_y       (req_y),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_id      (rsp_id),
      .grant_count (grant_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Operands are normal numbers whose mantissas use only the top 4 bits,
   // so every product is exact: (16+a)*(16+b) * 2^(ex+ey-262).
   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      int prod, p, e;
      logic [22:0] frac;
      prod = (16 + int'(x[22:19])) * (16 + int'(y[22:19]));
      p    = (prod >= 512) ? 9 : 8;
      e    = p + int'(x[30:23]) + int'(y[30:23]) - 135;
      frac = 23'((prod - (1 << p)) << (23 - p));
      return {x[31] ^ y[31], 8'(e), frac};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] v;
      v[31]    = 1'($urandom);
      v[30:23] = 8'($urandom_range(154, 100));
      v[22:19] = 4'($urandom);
      v[18:0]  = 19'd0;
      return v;
   endfunction

   task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y);
      req_valid[i]      = 1'b1;
      req_x[32*i +: 32] = x;
      req_y[32*i +: 32] = y;
   endtask

   task automatic model_reset();
      m0_v   = 1'b0;
      m1_v   = 1'b0;
      m_last = 3;
      m_cnt  = 16'd0;
   endtask

   // One clock cycle: called at a falling edge with inputs already applied.
   task automatic step();
      logic [3:0] exp_rdy;
      int  g;
      bit  adv;
      #1;
      adv = !m1_v || rsp_ready;
      g   = -1;
      if (adv) begin
         for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      exp_rdy = 4'b0000;
      if (g >= 0) exp_rdy[g] = 1'b1;
      obs_rdy = req_ready;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(m1_v));
      if (m1_v) begin
         check("rsp_data", rsp_data, m1_d);
         check("rsp_id", 32'(rsp_id), 32'(m1_id));
      end
      check("grant_count", 32'(grant_count), 32'(m_cnt));
      @(posedge clk);
      if (adv) begin
         m1_v  = m0_v;
         m1_d  = m0_d;
         m1_id = m0_id;
         m0_v  = (g >= 0);
         if (g >= 0) begin
            m0_d   = ref_mul(req_x[32*g +: 32], req_y[32*g +: 32]);
            m0_id  = g;
            m_last = g;
            m_cnt  = m_cnt + 16'd1;
         end
      end
      last_grant = g;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 4'hF;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      check("rst_grant_count", 32'(grant_count), 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      req_valid = 4'h0;
      rst_n     = 1'b1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      clk       = 1'b0;
      rst_n     = 1'b1;
      req_valid = 4'h0;
      req_x     = '0;
      req_y     = '0;
      rsp_ready = 1'b1;
      model_reset();
      #2;
      do_reset();

      // single request: 2.0 x 3.0
      set_req(0, 32'h4000_0000, 32'h4040_0000);
      step();
      check("single_ready", 32'(obs_rdy), 32'h1);
      req_valid = 4'h0;
      step();
      check("single_valid", 32'(rsp_valid), 32'h1);
      check("single_data", rsp_data, 32'h40C0_0000);
      check("single_id", 32'(rsp_id), 32'h0);
      check("single_count", 32'(grant_count), 32'h1);
      repeat (3) step();

      // round-robin with all requesters continuously valid
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, rand_fp(), rand_fp());
      for (int n = 0; n < 40; n++) begin
         step();
         check("rr_seq", 32'(last_grant), 32'(n % 4));
         if (last_grant >= 0) set_req(last_grant, rand_fp(), rand_fp());
      end
      req_valid = 4'h0;
      repeat (3) step();

      // backpressure: fill, stall 5 cycles, drain in order
      do_reset();
      set_req(0, 32'h3F80_0000, 32'h4000_0000);
      set_req(1, 32'hC000_0000, 32'h3F00_0000);
      set_req(2, rand_fp(), rand_fp());
      set_req(3, rand_fp(), rand_fp());
      repeat (2) begin
         step();
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      end
      rsp_ready = 1'b0;
      repeat (5) begin
         step();
         check("bp_ready_zero", 32'(obs_rdy), 32'h0);
         check("bp_hold_data", rsp_data, 32'h4000_0000);
         check("bp_hold_id", 32'(rsp_id), 32'h0);
      end
      rsp_ready = 1'b1;
      step();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      check("bp_drain_data", rsp_data, 32'hBF80_0000);
      check("bp_drain_id", 32'(rsp_id), 32'h1);
      repeat (6) begin
         step();
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      end

      // priority skip and wrap: last = 1, only req0 and req3 valid
      do_reset();
      set_req(0, rand_fp(), rand_fp());
      set_req(1, rand_fp(), rand_fp());
      repeat (2) begin
         step();
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      end
      set_req(0, rand_fp(), rand_fp());
      set_req(3, rand_fp(), rand_fp());
      step();
      check("skip_first", 32'(obs_rdy), 32'h8);
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      step();
      check("skip_second", 32'(obs_rdy), 32'h1);
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      repeat (3) step();

      // random traffic with random backpressure
      do_reset();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!req_valid[i] && ($urandom_range(1, 0) == 1)) set_req(i, rand_fp(), rand_fp());
         end
         rsp_ready = ($urandom_range(3, 0) != 0);
         step();
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      end
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      repeat (3) step();

      // reset while both stages are full
      do_reset();
      rsp_ready = 1'b0;
      set_req(0, rand_fp(), rand_fp());
      set_req(1, rand_fp(), rand_fp());
      repeat (2) begin
         step();
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      end
      set_req(2, rand_fp(), rand_fp());
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("midrst_req_ready", 32'(req_ready), 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 4; i++) set_req(i, rand_fp(), rand_fp());
      step();
      check("midrst_next_grant", 32'(obs_rdy), 32'h1);
      req_valid = 4'h0;
      repeat (3) step();

      // counter wrap: 65536 grants of 1.0 x 1.0
      do_reset();
      set_req(0, 32'h3F80_0000, 32'h3F80_0000);
      repeat (65536) step();
      check("cnt_wrap", 32'(grant_count), 32'h0);
      check("cnt_wrap_data", rsp_data, 32'h3F80_0000);
      req_valid = 4'h0;
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
